// File: rtl/i3c_daa_master_pkg.sv
// Shared definitions for the ENTDAA controller engine: state encodings,
// error codes and the reserved-address rule used by the pool allocator.
package i3c_daa_master_pkg;

   typedef enum logic [2:0] {
      DAAM_IDLE     = 3'd0,
      DAAM_WAIT_HDR = 3'd1,
      DAAM_ID       = 3'd2,
      DAAM_DA       = 3'd3,
      DAAM_ACK      = 3'd4,
      DAAM_DONE     = 3'd5
   } daam_state_e;

   localparam logic [1:0] DAAM_ERR_NONE = 2'b00;
   localparam logic [1:0] DAAM_ERR_NACK = 2'b01;
   localparam logic [1:0] DAAM_ERR_POOL = 2'b10;

   // Highest address the pool may hand out; anything above is exhausted.
   localparam logic [7:0] DAAM_ADDR_TOP = 8'h7D;

   function automatic logic daam_is_reserved(input logic [6:0] a);
      return (a < 7'h08) || (a == 7'h3E) || (a == 7'h5E) || (a == 7'h6E) ||
             (a == 7'h76) || (a == 7'h7A) || (a == 7'h7C) || (a == 7'h7E) ||
             (a == 7'h7F);
   endfunction

endpackage

// File: rtl/i3c_daa_addr_alloc.sv
// Combinational dynamic-address search: first non-reserved address >= cand,
// with an exhausted flag when the result leaves the usable pool.
module i3c_daa_addr_alloc
   import i3c_daa_master_pkg::*;
(
   input  logic [7:0] cand,
   output logic [6:0] addr,
   output logic       exhausted
);

   logic [7:0] c0, c1, c2;

   // Reserved values in the usable range never come in runs longer than two.
   always_comb begin
      c0 = (cand < 8'h08) ? 8'h08 : cand;
      c1 = c0;
      if (!c0[7] && daam_is_reserved(c0[6:0])) c1 = c0 + 8'd1;
      c2 = c1;
      if (!c1[7] && daam_is_reserved(c1[6:0])) c2 = c1 + 8'd1;
      addr      = c2[6:0];
      exhausted = (c2 > DAAM_ADDR_TOP);
   end

endmodule

// File: rtl/i3c_daa_master.sv
// Controller-side ENTDAA round sequencer: header request, ID capture, DA drive
// with odd parity, ACK sampling. Macro I3C_DAA_MSTR_FULLID_EN keeps the full 64-bit ID.
// SDA handshake: sda_oe/sda_out are registered on the rising edge and launched
// by the bus engine at the following falling edge; sda_in is the rising-edge sample.
module i3c_daa_master
   import i3c_daa_master_pkg::*;
#(
   parameter int unsigned MAX_NACK = 3,
   parameter logic [6:0]  ADDR_MIN = 7'h08
) (
   input  logic        clk_SCL,
   input  logic        RSTn,
   input  logic        daa_start,
   input  logic        daa_abort,
   input  logic [6:0]  da_base,
   input  logic        hdr_valid,
   input  logic        hdr_ack,
   input  logic        sda_in,
   output logic        sda_oe,
   output logic        sda_out,
   output logic        need_sr,
   output logic        need_stop,
   output logic        daa_busy,
   output logic        res_valid,
   output logic [63:0] res_id,
   output logic [6:0]  res_da,
   output logic [6:0]  dev_cnt,
   output logic        daa_err,
   output logic [1:0]  err_cause,
   output logic [2:0]  dbg_state
);

`ifdef I3C_DAA_MSTR_FULLID_EN
   localparam int ID_W = 64;
`else
   localparam int ID_W = 16;
`endif

   daam_state_e     state_q, state_d;
   logic [5:0]      bit_cnt_q, bit_cnt_d;
   logic [ID_W-1:0] id_q, id_d, res_id_q, res_id_d;
   logic [6:0]      next_da_q, next_da_d, res_da_q, res_da_d;
   logic [6:0]      dev_q, dev_d;
   logic [2:0]      nack_q, nack_d;
   logic [3:0]      nack_inc;
   logic            err_q, err_d, oe_q, oe_d, out_q, out_d, rv_q, rv_d;
   logic [1:0]      cause_q, cause_d;
   logic [6:0]      base_eff, alloc_addr;
   logic [7:0]      alloc_cand;
   logic            alloc_exh;

   assign base_eff   = (da_base < ADDR_MIN) ? ADDR_MIN : da_base;
   assign alloc_cand = (state_q == DAAM_IDLE) ? {1'b0, base_eff} : ({1'b0, next_da_q} + 8'd1);
   assign nack_inc   = {1'b0, nack_q} + 4'd1;

   i3c_daa_addr_alloc u_alloc (
      .cand      (alloc_cand),
      .addr      (alloc_addr),
      .exhausted (alloc_exh)
   );

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      id_d      = id_q;
      next_da_d = next_da_q;
      dev_d     = dev_q;
      nack_d    = nack_q;
      err_d     = err_q;
      cause_d   = cause_q;
      oe_d      = oe_q;
      out_d     = out_q;
      rv_d      = 1'b0;
      res_id_d  = res_id_q;
      res_da_d  = res_da_q;
      if (daa_abort) begin
         state_d = DAAM_IDLE;
         oe_d    = 1'b0;
      end else begin
         case (state_q)
            DAAM_IDLE: if (daa_start) begin
               next_da_d = alloc_addr;
               dev_d     = 7'd0;
               nack_d    = 3'd0;
               err_d     = 1'b0;
               cause_d   = DAAM_ERR_NONE;
               if (alloc_exh) begin
                  state_d = DAAM_DONE;
                  err_d   = 1'b1;
                  cause_d = DAAM_ERR_POOL;
               end else begin
                  state_d = DAAM_WAIT_HDR;
               end
            end
            DAAM_WAIT_HDR: if (hdr_valid) begin
               state_d   = hdr_ack ? DAAM_ID : DAAM_DONE;
               bit_cnt_d = 6'd63;
            end
            DAAM_ID: begin
               // Shifting all 64 bits through a narrower register keeps BCR/DCR.
               id_d = {id_q[ID_W-2:0], sda_in};
               oe_d = 1'b0;
               if (bit_cnt_q == 6'd0) begin
                  state_d = DAAM_DA;
                  oe_d    = 1'b1;
                  out_d   = next_da_q[6];
               end else begin
                  bit_cnt_d = bit_cnt_q - 6'd1;
               end
            end
            DAAM_DA: begin
               if (bit_cnt_q < 6'd6) begin
                  out_d     = next_da_q[3'd5 - bit_cnt_q[2:0]];
                  bit_cnt_d = bit_cnt_q + 6'd1;
               end else if (bit_cnt_q == 6'd6) begin
                  out_d     = ~^next_da_q;
                  bit_cnt_d = bit_cnt_q + 6'd1;
               end else begin
                  oe_d    = 1'b0;
                  out_d   = 1'b0;
                  state_d = DAAM_ACK;
               end
            end
            DAAM_ACK: begin
               if (!sda_in) begin
                  rv_d      = 1'b1;
                  res_id_d  = id_q;
                  res_da_d  = next_da_q;
                  nack_d    = 3'd0;
                  next_da_d = alloc_addr;
                  if (dev_q != 7'h7F) dev_d = dev_q + 7'd1;
                  if (alloc_exh) begin
                     state_d = DAAM_DONE;
                     err_d   = 1'b1;
                     cause_d = DAAM_ERR_POOL;
                  end else begin
                     state_d = DAAM_WAIT_HDR;
                  end
               end else begin
                  nack_d = nack_inc[2:0];
                  if (nack_inc >= 4'(MAX_NACK)) begin
                     state_d = DAAM_DONE;
                     err_d   = 1'b1;
                     cause_d = DAAM_ERR_NACK;
                  end else begin
                     state_d = DAAM_WAIT_HDR;
                  end
               end
            end
            DAAM_DONE: state_d = DAAM_IDLE;
            default:   state_d = DAAM_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_SCL or negedge RSTn) begin
      if (!RSTn) begin
         state_q   <= DAAM_IDLE;
         bit_cnt_q <= '0;
         id_q      <= '0;
         next_da_q <= '0;
         dev_q     <= '0;
         nack_q    <= '0;
         err_q     <= 1'b0;
         cause_q   <= '0;
         oe_q      <= 1'b0;
         out_q     <= 1'b0;
         rv_q      <= 1'b0;
         res_id_q  <= '0;
         res_da_q  <= '0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         id_q      <= id_d;
         next_da_q <= next_da_d;
         dev_q     <= dev_d;
         nack_q    <= nack_d;
         err_q     <= err_d;
         cause_q   <= cause_d;
         oe_q      <= oe_d;
         out_q     <= out_d;
         rv_q      <= rv_d;
         res_id_q  <= res_id_d;
         res_da_q  <= res_da_d;
      end
   end

   assign sda_oe    = oe_q;
   assign sda_out   = out_q;
   assign need_sr   = (state_q == DAAM_WAIT_HDR);
   assign need_stop = (state_q == DAAM_DONE);
   assign daa_busy  = (state_q != DAAM_IDLE);
   assign res_valid = rv_q;
   assign res_id    = 64'(res_id_q);
   assign res_da    = res_da_q;
   assign dev_cnt   = dev_q;
   assign daa_err   = err_q;
   assign err_cause = cause_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_i3c_daa_master.sv
// Bench for i3c_daa_master: directed sessions plus random sessions, checked
// against an address-pool / ENTDAA model. Inputs change on falling edges.
module tb_i3c_daa_master;

   localparam int MAX_NACK = 3;

   logic        clk_SCL = 1'b0;
   logic        RSTn = 1'b0;
   logic        daa_start = 1'b0, daa_abort = 1'b0;
   logic [6:0]  da_base = 7'h00;
   logic        hdr_valid = 1'b0, hdr_ack = 1'b0, sda_in = 1'b1;
   logic        sda_oe, sda_out, need_sr, need_stop, daa_busy, res_valid;
   logic [63:0] res_id;
   logic [6:0]  res_da, dev_cnt;
   logic        daa_err;
   logic [1:0]  err_cause;
   logic [2:0]  dbg_state;

   int n_cmp = 0;
   int n_err = 0;
   int res_cnt = 0;
   int push_cnt = 0;
   logic [70:0] exp_q[$];

   // Reference model of the session
   int          m_next, m_dev, m_nack;
   bit          m_done;
   logic        m_err;
   logic [1:0]  m_cause;

   i3c_daa_master #(.MAX_NACK(MAX_NACK), .ADDR_MIN(7'h08)) dut (
      .clk_SCL(clk_SCL), .RSTn(RSTn), .daa_start(daa_start), .daa_abort(daa_abort),
      .da_base(da_base), .hdr_valid(hdr_valid), .hdr_ack(hdr_ack), .sda_in(sda_in),
      .sda_oe(sda_oe), .sda_out(sda_out), .need_sr(need_sr), .need_stop(need_stop),
      .daa_busy(daa_busy), .res_valid(res_valid), .res_id(res_id), .res_da(res_da),
      .dev_cnt(dev_cnt), .daa_err(daa_err), .err_cause(err_cause), .dbg_state(dbg_state)
   );

   always #5 clk_SCL = ~clk_SCL;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit ref_reserved(input int a);
      int rsv[8] = '{'h3E, 'h5E, 'h6E, 'h76, 'h7A, 'h7C, 'h7E, 'h7F};
      if (a < 8) return 1'b1;
      foreach (rsv[i]) if (rsv[i] == a) return 1'b1;
      return 1'b0;
   endfunction

   // First usable address >= a, or -1 when the pool is used up.
   function automatic int ref_alloc(input int a);
      for (int x = a; x < 128; x++)
         if (!ref_reserved(x)) return (x > 'h7D) ? -1 : x;
      return -1;
   endfunction

   function automatic logic [63:0] ref_id(input logic [63:0] id);
`ifdef I3C_DAA_MSTR_FULLID_EN
      return id;
`else
      return {48'd0, id[15:0]};
`endif
   endfunction

   always @(negedge clk_SCL) begin
      if (RSTn && res_valid) begin
         logic [70:0] e;
         res_cnt++;
         if (exp_q.size() == 0) chk("res_unexpected", 64'd1, 64'd0);
         else begin
            e = exp_q.pop_front();
            chk("res_da", 64'(res_da), 64'(e[70:64]));
            chk("res_id", res_id, e[63:0]);
         end
      end
   end

   task automatic do_reset();
      RSTn = 1'b0;
      repeat (2) @(negedge clk_SCL);
      RSTn = 1'b1;
      @(negedge clk_SCL);
   endtask

   task automatic check_done(input string tag);
      chk({tag, "_need_stop"}, 64'(need_stop), 64'd1);
      chk({tag, "_err"}, 64'(daa_err), 64'(m_err));
      chk({tag, "_cause"}, 64'(err_cause), 64'(m_cause));
      chk({tag, "_dev_cnt"}, 64'(dev_cnt), 64'(m_dev));
      @(negedge clk_SCL);
      chk({tag, "_idle"}, 64'(daa_busy), 64'd0);
      chk({tag, "_no_sr"}, 64'(need_sr), 64'd0);
      chk({tag, "_stop_pulse"}, 64'(need_stop), 64'd0);
   endtask

   task automatic start_daa(input logic [6:0] base);
      m_next = ref_alloc((base < 8) ? 8 : int'(base));
      m_dev = 0; m_nack = 0; m_err = 1'b0; m_cause = 2'b00; m_done = 1'b0;
      da_base = base; daa_start = 1'b1;
      @(negedge clk_SCL);
      daa_start = 1'b0;
      chk("start_dev_cnt", 64'(dev_cnt), 64'd0);
      if (m_next < 0) begin
         m_done = 1'b1; m_err = 1'b1; m_cause = 2'b10;
         check_done("start_pool");
      end else begin
         chk("start_need_sr", 64'(need_sr), 64'd1);
      end
   endtask

   // One ENTDAA round: header ACK, 64 ID bits, observe DA byte, answer ACK/NACK.
   task automatic round(input logic [63:0] id, input bit ack);
      logic [7:0] obs;
      logic       par;
      hdr_valid = 1'b1; hdr_ack = 1'b1;
      @(negedge clk_SCL);
      hdr_valid = 1'b0; hdr_ack = 1'b0;
      for (int i = 63; i >= 0; i--) begin
         sda_in = id[i];
         @(negedge clk_SCL);
      end
      for (int k = 7; k >= 0; k--) begin
         if (sda_oe !== 1'b1) chk("da_sda_oe", 64'(sda_oe), 64'd1);
         obs[k] = sda_out;
         @(negedge clk_SCL);
      end
      par = ($countones(m_next[6:0]) % 2 == 0) ? 1'b1 : 1'b0;
      chk("da_byte", 64'(obs), 64'({m_next[6:0], par}));
      chk("ack_sda_oe", 64'(sda_oe), 64'd0);
      sda_in = ack ? 1'b0 : 1'b1;
      if (ack) begin
         exp_q.push_back({m_next[6:0], ref_id(id)});
         push_cnt++;
      end
      @(negedge clk_SCL);
      sda_in = 1'b1;
      if (ack) begin
         if (m_dev < 127) m_dev++;
         m_nack = 0;
         m_next = ref_alloc(m_next + 1);
         if (m_next < 0) begin m_done = 1'b1; m_err = 1'b1; m_cause = 2'b10; end
      end else begin
         m_nack++;
         if (m_nack >= MAX_NACK) begin m_done = 1'b1; m_err = 1'b1; m_cause = 2'b01; end
      end
      if (m_done) check_done("round_end");
      else begin
         chk("round_need_sr", 64'(need_sr), 64'd1);
         chk("round_dev_cnt", 64'(dev_cnt), 64'(m_dev));
      end
   endtask

   task automatic hdr_nack();
      hdr_valid = 1'b1; hdr_ack = 1'b0;
      @(negedge clk_SCL);
      hdr_valid = 1'b0;
      m_done = 1'b1;
      check_done("hdr_nack");
   endtask

   initial begin
      logic [63:0] rid;
      do_reset();
      chk("rst_busy", 64'(daa_busy), 64'd0);
      chk("rst_oe", 64'(sda_oe), 64'd0);
      chk("rst_out", 64'(sda_out), 64'd0);
      chk("rst_sr", 64'(need_sr), 64'd0);
      chk("rst_stop", 64'(need_stop), 64'd0);
      chk("rst_rv", 64'(res_valid), 64'd0);
      chk("rst_id", res_id, 64'd0);
      chk("rst_da", 64'(res_da), 64'd0);
      chk("rst_cnt", 64'(dev_cnt), 64'd0);
      chk("rst_err", 64'({daa_err, err_cause}), 64'd0);

      // Two targets from 0x08
      start_daa(7'h08);
      round(64'h0123456789AB_C0_45, 1'b1);
      round({$urandom, $urandom}, 1'b1);
      hdr_nack();
      chk("two_dev_cnt", 64'(dev_cnt), 64'd2);

      // Reserved 0x3E skipped
      start_daa(7'h3D);
      round({$urandom, $urandom}, 1'b1);
      round({$urandom, $urandom}, 1'b1);
      hdr_nack();

      // Two NACKs then ACK: same DA three times
      start_daa(7'h20);
      round({$urandom, $urandom}, 1'b0);
      round({$urandom, $urandom}, 1'b0);
      round({$urandom, $urandom}, 1'b1);
      hdr_nack();

      // NACK limit
      start_daa(7'h30);
      for (int r = 0; r < MAX_NACK; r++) round({$urandom, $urandom}, 1'b0);

      // Pool exhaustion after last address, and at start
      start_daa(7'h7D);
      round({$urandom, $urandom}, 1'b1);
      start_daa(7'h7E);

      // Abort while the ID bit 30 is being sampled
      start_daa(7'h10);
      rid = {$urandom, $urandom};
      hdr_valid = 1'b1; hdr_ack = 1'b1;
      @(negedge clk_SCL);
      hdr_valid = 1'b0; hdr_ack = 1'b0;
      for (int i = 63; i > 30; i--) begin sda_in = rid[i]; @(negedge clk_SCL); end
      daa_abort = 1'b1; sda_in = rid[30];
      @(negedge clk_SCL);
      daa_abort = 1'b0;
      chk("abort_busy", 64'(daa_busy), 64'd0);
      chk("abort_oe", 64'(sda_oe), 64'd0);
      chk("abort_sr", 64'(need_sr), 64'd0);
      chk("abort_err", 64'(daa_err), 64'd0);
      @(negedge clk_SCL);
      chk("abort_stay_idle", 64'(daa_busy), 64'd0);

      // Reset during DA bit 3
      start_daa(7'h10);
      hdr_valid = 1'b1; hdr_ack = 1'b1;
      @(negedge clk_SCL);
      hdr_valid = 1'b0; hdr_ack = 1'b0;
      for (int i = 0; i < 64 + 3; i++) @(negedge clk_SCL);
      chk("pre_rst_oe", 64'(sda_oe), 64'd1);
      RSTn = 1'b0;
      #1;
      chk("mid_rst_busy", 64'(daa_busy), 64'd0);
      chk("mid_rst_oe", 64'(sda_oe), 64'd0);
      chk("mid_rst_out", 64'({sda_out, need_sr, need_stop, res_valid}), 64'd0);
      @(negedge clk_SCL);
      RSTn = 1'b1;
      @(negedge clk_SCL);
      chk("post_rst_busy", 64'(daa_busy), 64'd0);

      // Random sessions
      for (int s = 0; s < 5; s++) begin
         start_daa(7'($urandom_range(8, 'h7D)));
         for (int r = 0; r < 4 && !m_done; r++)
            round({$urandom, $urandom}, $urandom_range(0, 3) != 0);
         if (!m_done) hdr_nack();
      end

      repeat (2) @(negedge clk_SCL);
      chk("res_count", 64'(res_cnt), 64'(push_cnt));
      chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
